// File: rtl/spike_filter_reporter_pkg.sv
// Shared types and helpers for the spike filter reporter.
// - sfr_state_e : output serializer states
// - FIRST/SECOND: value of the marker bit (MSB) of each host word
// - pack_words  : builds the two host words for one (idx, state) sample. Widths
//                 are passed as arguments so that both the RTL and a host-side
//                 decoder can use it for any parameterisation up to MAX_W bits.
package spike_filter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } sfr_state_e;

  localparam int STATE_LO_BITS = 16;
  localparam logic FIRST  = 1'b0;
  localparam logic SECOND = 1'b1;

  // Widest host word the helper can produce.
  localparam int MAX_W = 64;

  typedef struct packed {
    logic [MAX_W-1:0] word0;
    logic [MAX_W-1:0] word1;
  } word_pair_t;

  // word0 = {FIRST,  pad, idx, state[nstate-1:16]}
  // word1 = {SECOND, pad, state[15:0]}
  function automatic word_pair_t pack_words(input int nfilts, input int nstate,
                                            input int nout,
                                            input logic [MAX_W-1:0] idx,
                                            input logic [MAX_W-1:0] state);
    word_pair_t p;
    logic [MAX_W-1:0] idx_m;
    logic [MAX_W-1:0] st_m;
    idx_m = idx & ((64'd1 << nfilts) - 64'd1);
    st_m  = state & ((64'd1 << nstate) - 64'd1);
    p.word0 = (64'(FIRST) << (nout - 1))
            | (idx_m << (nstate - STATE_LO_BITS))
            | (st_m >> STATE_LO_BITS);
    p.word1 = (64'(SECOND) << (nout - 1)) | (st_m & 64'hFFFF);
    return p;
  endfunction

endpackage

// File: rtl/spike_filter_reporter_if.sv
// Channels used by the spike filter reporter.
// SpikeFilterOutputChannel: one (filt_idx, filt_state) sample per transfer,
//   v/a handshake (transfer when v & a at clk edge).
// Channel: generic N-bit data word with v/a handshake.
interface SpikeFilterOutputChannel #(
  parameter int Nfilts = 10,
  parameter int Nstate = 27
);
  logic              v;
  logic              a;
  logic [Nfilts-1:0] filt_idx;
  logic [Nstate-1:0] filt_state;

  modport master (output v, filt_idx, filt_state, input a);
  modport slave  (input v, filt_idx, filt_state, output a);
endinterface

interface Channel #(
  parameter int N = 32
);
  logic         v;
  logic         a;
  logic [N-1:0] d;

  modport master (output v, d, input a);
  modport slave  (input v, d, output a);
endinterface

// File: rtl/spike_filter_reporter_decimator.sv
// spike_frame_decimator: decides which filter sweeps ("frames") get reported.
// A frame starts at every accepted sample with filt_idx == 0; one frame in
// report_every is reported, report_every == 0 disables reporting.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   accept            a sample is transferred this cycle
//   idx_is_zero       current sample carries filt_idx == 0
//   report_every      decimation factor, sampled only at frame start
//   report_frame_eff  report decision valid for the current sample
module spike_frame_decimator (
  input  logic       clk,
  input  logic       reset,
  input  logic       accept,
  input  logic       idx_is_zero,
  input  logic [7:0] report_every,
  output logic       report_frame_eff
);

  logic [7:0] frame_ct;
  logic       report_frame;
  logic [7:0] rpt_k;
  logic       new_report;
  logic [8:0] ct_inc;

  // rpt_k is only consumed at the frame start it is captured on, so it is
  // used directly rather than held in a register.
  assign rpt_k      = report_every;
  assign new_report = (rpt_k != 8'd0) && (frame_ct == 8'd0);
  assign ct_inc     = {1'b0, frame_ct} + 9'd1;

  // The idx 0 sample itself already belongs to the new frame.
  assign report_frame_eff = idx_is_zero ? new_report : report_frame;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_ct     <= 8'd0;
      report_frame <= 1'b0;
    end else if (accept && idx_is_zero) begin
      report_frame <= new_report;
      frame_ct     <= (ct_inc >= {1'b0, rpt_k}) ? 8'd0 : ct_inc[7:0];
    end
  end

endmodule

// File: rtl/spike_filter_reporter.sv
// spike_filter_reporter: decimates filter-array sweeps, optionally drops
// zero states, and serialises each kept sample into two host words.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   in            samples from the filter array (slave side)
//   out           host words, marker in bit Nout-1 (master side)
//   report_every  0 = off, k = report one frame in k
//   skip_zero     drop samples whose state is zero
//   sat_warn      sticky: an accepted sample had its state MSB set
//   clr_warn      clears sat_warn (a coincident set wins)
// Nout must be below pack_words' MAX_W.
module spike_filter_reporter
  import spike_filter_pkg::*;
#(
  parameter int Nfilts = 10,
  parameter int Nstate = 27,
  parameter int Nout   = 32
) (
  input  logic       clk,
  input  logic       reset,
  SpikeFilterOutputChannel.slave in,
  Channel.master     out,
  input  logic [7:0] report_every,
  input  logic       skip_zero,
  output logic       sat_warn,
  input  logic       clr_warn
);

  sfr_state_e      state;
  logic            accept;
  logic            keep;
  logic            report_frame_eff;
  logic            idx_is_zero;
  logic            state_is_zero;
  logic [Nout-1:0] word1_q;
  word_pair_t      packed_w;
  logic            unused_pack_hi;

  assign idx_is_zero   = (in.filt_idx == '0);
  assign state_is_zero = (in.filt_state == '0);

  // The upstream array stalls its whole pipeline while a sample is pending,
  // so the ack depends only on our own state and the downstream ack.
  assign in.a   = in.v & ((state == IDLE) | ((state == SEND1) & out.a));
  assign accept = in.a;
  assign keep   = report_frame_eff & ~(skip_zero & state_is_zero);

  always_comb begin
    packed_w = pack_words(Nfilts, Nstate, Nout,
                          {{(MAX_W-Nfilts){1'b0}}, in.filt_idx},
                          {{(MAX_W-Nstate){1'b0}}, in.filt_state});
  end

  // Bits above the host word width are always zero.
  assign unused_pack_hi = ^{packed_w.word0[MAX_W-1:Nout], packed_w.word1[MAX_W-1:Nout]};

  spike_frame_decimator u_decimator (
    .clk              (clk),
    .reset            (reset),
    .accept           (accept),
    .idx_is_zero      (idx_is_zero),
    .report_every     (report_every),
    .report_frame_eff (report_frame_eff)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      out.v    <= 1'b0;
      out.d    <= '0;
      word1_q  <= '0;
      sat_warn <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && keep) begin
            state   <= SEND0;
            out.v   <= 1'b1;
            out.d   <= packed_w.word0[Nout-1:0];
            word1_q <= packed_w.word1[Nout-1:0];
          end
        end
        SEND0: begin
          if (out.a) begin
            state <= SEND1;
            out.d <= word1_q;
          end
        end
        SEND1: begin
          if (out.a) begin
            // Back-to-back: a kept sample taken with word1's ack goes
            // straight out without an idle bubble.
            if (accept && keep) begin
              state   <= SEND0;
              out.d   <= packed_w.word0[Nout-1:0];
              word1_q <= packed_w.word1[Nout-1:0];
            end else begin
              state <= IDLE;
              out.v <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          out.v <= 1'b0;
        end
      endcase

      if (accept && in.filt_state[Nstate-1]) begin
        sat_warn <= 1'b1;
      end else if (clr_warn) begin
        sat_warn <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_filter_reporter.sv
module tb_spike_filter_reporter;

  logic       clk;
  logic       reset;
  logic [7:0] report_every;
  logic       skip_zero;
  logic       sat_warn;
  logic       clr_warn;

  SpikeFilterOutputChannel #(.Nfilts(10), .Nstate(27)) sin();
  Channel #(.N(32)) sout();

  spike_filter_reporter #(.Nfilts(10), .Nstate(27), .Nout(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .in           (sin),
    .out          (sout),
    .report_every (report_every),
    .skip_zero    (skip_zero),
    .sat_warn     (sat_warn),
    .clr_warn     (clr_warn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int acks = 0;
  bit seen_v = 0;

  // Reference model: frame bookkeeping in plain integers, words by arithmetic.
  int m_ct = 0;
  bit m_rf = 0;

  always @(negedge clk) begin
    if (reset) begin
      m_ct = 0;
      m_rf = 0;
      exp_q.delete();
      got_q.delete();
    end else begin
      if (sin.v && sin.a) begin
        acks++;
        if (sin.filt_idx == 10'd0) begin
          m_rf = (report_every != 8'd0) && (m_ct == 0);
          m_ct = (m_ct + 1 >= int'(report_every)) ? 0 : m_ct + 1;
        end
        if (m_rf && !(skip_zero && sin.filt_state == 27'd0)) begin
          exp_q.push_back((32'(sin.filt_idx) << 11) | (32'(sin.filt_state) >> 16));
          exp_q.push_back(32'h8000_0000 | (32'(sin.filt_state) & 32'h0000_FFFF));
        end
      end
      if (sout.v) seen_v = 1;
      if (sout.v && sout.a) got_q.push_back(sout.d);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int idx, input logic [26:0] st);
    int n = 0;
    sin.v = 1'b1;
    sin.filt_idx = 10'(idx);
    sin.filt_state = st;
    @(negedge clk);
    while (!sin.a && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!sin.a) begin
      errors++;
      $display("FAIL send_ack: idx %0d never acked (in.a=%b, required 1)", idx, sin.a);
    end
    tick();
    sin.v = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    sin.v = 1'b0;
    sout.a = 1'b1;
    @(negedge clk);
    while (sout.v && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sout.v) begin
      errors++;
      $display("FAIL drain: out.v=%b after %0d cycles, required 0", sout.v, n);
    end
    tick();
  endtask

  function automatic logic [26:0] rand_state();
    int r;
    logic [26:0] s;
    r = $urandom_range(0, 3);
    s = 27'($urandom);
    if (r == 0) s = '0;
    else if (r == 1) s[26] = 1'b1;
    else s[26] = 1'b0;
    return s;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    sin.v = 1'b0;
    sout.a = 1'b0;
    clr_warn = 1'b0;
    report_every = 8'd1;
    skip_zero = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (sout.v !== 1'b0) begin errors++; $display("FAIL reset_outv: got %b required 0", sout.v); end
    checks++;
    if (sat_warn !== 1'b0) begin errors++; $display("FAIL reset_satwarn: got %b required 0", sat_warn); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [31:0] e[4];
    int a0;
    e = '{32'h0000_0000, 32'h8000_0005, 32'h0000_1923, 32'h8000_4567};
    report_every = 8'd1;
    skip_zero = 1'b0;
    sout.a = 1'b1;
    got_q.delete();
    send(0, 27'h5);
    drain();
    a0 = acks;
    sin.v = 1'b1;
    sin.filt_idx = 10'd3;
    sin.filt_state = 27'h123_4567;
    @(negedge clk);
    checks++;
    if (sin.a !== 1'b1) begin errors++; $display("FAIL single_ack: in.a=%b required 1", sin.a); end
    tick();
    sin.v = 1'b0;
    @(negedge clk);
    checks++;
    if (sout.v !== 1'b1 || sout.d !== 32'h0000_1923) begin
      errors++; $display("FAIL single_word0: v=%b d=%h required v=1 d=00001923", sout.v, sout.d);
    end
    @(negedge clk);
    checks++;
    if (sout.v !== 1'b1 || sout.d !== 32'h8000_4567) begin
      errors++; $display("FAIL single_word1: v=%b d=%h required v=1 d=80004567", sout.v, sout.d);
    end
    @(negedge clk);
    checks++;
    if (sout.v !== 1'b0) begin errors++; $display("FAIL single_idle: v=%b required 0", sout.v); end
    checks++;
    if (acks - a0 !== 1) begin errors++; $display("FAIL single_ackcount: got %0d required 1", acks - a0); end
    tick();
    checks++;
    if (got_q.size() !== 4) begin
      errors++; $display("FAIL single_count: got %0d words required 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] !== e[i]) begin errors++; $display("FAIL single_seq[%0d]: got %h required %h", i, got_q[i], e[i]); end
      end
    end
  endtask

  task automatic test_decimate();
    logic [31:0] e[4];
    int a0;
    e = '{32'h0000_0000, 32'h8000_0005, 32'h0000_0000, 32'h8000_0005};
    report_every = 8'd2;
    skip_zero = 1'b1;
    sout.a = 1'b1;
    got_q.delete();
    a0 = acks;
    for (int s = 0; s < 4; s++) begin
      send(0, 27'h5);
      send(1, 27'h0);
    end
    drain();
    checks++;
    if (acks - a0 !== 8) begin errors++; $display("FAIL decim_acks: got %0d required 8", acks - a0); end
    checks++;
    if (got_q.size() !== 4) begin
      errors++; $display("FAIL decim_count: got %0d words required 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] !== e[i]) begin errors++; $display("FAIL decim_seq[%0d]: got %h required %h", i, got_q[i], e[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e[4];
    e = '{32'h0000_0000, 32'h8000_0007, 32'h0000_0801, 32'h8000_0000};
    report_every = 8'd1;
    skip_zero = 1'b0;
    sout.a = 1'b0;
    sin.v = 1'b1;
    sin.filt_idx = 10'd0;
    sin.filt_state = 27'h7;
    @(negedge clk);
    tick();
    sin.filt_idx = 10'd1;
    sin.filt_state = 27'h1_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (sout.v !== 1'b1 || sout.d !== 32'h0 || sin.a !== 1'b0) begin
        errors++; $display("FAIL stall[%0d]: v=%b d=%h in.a=%b required v=1 d=00000000 in.a=0", i, sout.v, sout.d, sin.a);
      end
      tick();
    end
    sout.a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (sout.v !== 1'b1 || sout.d !== e[i]) begin
        errors++; $display("FAIL b2b[%0d]: v=%b d=%h required v=1 d=%h", i, sout.v, sout.d, e[i]);
      end
      if (i == 1) begin
        checks++;
        if (sin.a !== 1'b1) begin errors++; $display("FAIL b2b_ack: in.a=%b required 1", sin.a); end
      end
      tick();
      if (i == 1) sin.v = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (sout.v !== 1'b0) begin errors++; $display("FAIL b2b_idle: v=%b required 0", sout.v); end
    drain();
  endtask

  task automatic test_off_then_on();
    logic [31:0] e[4];
    int a0;
    e = '{32'h0000_0000, 32'h8000_0007, 32'h0000_0800, 32'h8000_0008};
    report_every = 8'd0;
    skip_zero = 1'b0;
    sout.a = 1'b1;
    got_q.delete();
    seen_v = 0;
    a0 = acks;
    send(0, 27'h1); send(1, 27'h2); send(2, 27'h3);
    send(0, 27'h4);
    report_every = 8'd1;
    send(1, 27'h5); send(2, 27'h6);
    drain();
    checks++;
    if (seen_v !== 1'b0) begin errors++; $display("FAIL off_outv: out.v seen=%b required 0", seen_v); end
    send(0, 27'h7); send(1, 27'h8);
    drain();
    checks++;
    if (acks - a0 !== 8) begin errors++; $display("FAIL off_acks: got %0d required 8", acks - a0); end
    checks++;
    if (got_q.size() !== 4) begin
      errors++; $display("FAIL on_count: got %0d words required 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] !== e[i]) begin errors++; $display("FAIL on_seq[%0d]: got %h required %h", i, got_q[i], e[i]); end
      end
    end
  endtask

  task automatic test_sat_warn();
    report_every = 8'd0;
    skip_zero = 1'b1;
    sout.a = 1'b1;
    send(0, 27'h400_0000);
    @(negedge clk);
    checks++;
    if (sat_warn !== 1'b1) begin errors++; $display("FAIL sat_set: got %b required 1", sat_warn); end
    repeat (5) tick();
    @(negedge clk);
    checks++;
    if (sat_warn !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b required 1", sat_warn); end
    tick();
    clr_warn = 1'b1;
    tick();
    clr_warn = 1'b0;
    @(negedge clk);
    checks++;
    if (sat_warn !== 1'b0) begin errors++; $display("FAIL sat_clear: got %b required 0", sat_warn); end
    tick();
    clr_warn = 1'b1;
    send(1, 27'h400_0123);
    clr_warn = 1'b0;
    @(negedge clk);
    checks++;
    if (sat_warn !== 1'b1) begin errors++; $display("FAIL sat_set_beats_clr: got %b required 1", sat_warn); end
    tick();
    clr_warn = 1'b1;
    tick();
    clr_warn = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid_packet();
    report_every = 8'd3;
    skip_zero = 1'b0;
    sout.a = 1'b0;
    send(0, 27'h9);
    @(negedge clk);
    checks++;
    if (sout.v !== 1'b1) begin errors++; $display("FAIL rst_pre: out.v=%b required 1", sout.v); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (sout.v !== 1'b0) begin errors++; $display("FAIL rst_outv: out.v=%b required 0", sout.v); end
    tick();
    got_q.delete();
    sout.a = 1'b1;
    send(0, 27'hA);
    drain();
    send(0, 27'hB);
    drain();
    checks++;
    if (got_q.size() !== 2) begin
      errors++; $display("FAIL rst_count: got %0d words required 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 32'h0 || got_q[1] !== 32'h8000_000A) begin
        errors++; $display("FAIL rst_seq: got %h %h required 00000000 8000000a", got_q[0], got_q[1]);
      end
    end
  endtask

  task automatic test_random();
    int idx = 0;
    bit hs = 0;
    bit held = 0;
    bit exp_a;
    logic [31:0] held_d = '0;
    drain();
    got_q.delete();
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (hs) begin
        idx = (idx + 1) % 4;
        sin.v = 1'b0;
      end
      if ($urandom_range(0, 99) < 3) report_every = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 3) skip_zero = 1'($urandom_range(0, 1));
      if (!sin.v && $urandom_range(0, 3) != 0) begin
        sin.v = 1'b1;
        sin.filt_idx = 10'(idx);
        sin.filt_state = rand_state();
      end
      sout.a = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      hs = sin.v && sin.a;
      exp_a = sin.v && (!sout.v || (sout.d[31] && sout.a));
      checks++;
      if (sin.a !== exp_a) begin
        errors++; $display("FAIL rand_ack cyc %0d: in.a=%b required %b", cyc, sin.a, exp_a);
      end
      if (held) begin
        checks++;
        if (sout.v !== 1'b1 || sout.d !== held_d) begin
          errors++; $display("FAIL rand_stable cyc %0d: v=%b d=%h required v=1 d=%h", cyc, sout.v, sout.d, held_d);
        end
      end
      held = sout.v && !sout.a;
      held_d = sout.d;
    end
    tick();
    if (hs) sin.v = 1'b0;
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d words required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_word[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    sin.v = 1'b0;
    sin.filt_idx = '0;
    sin.filt_state = '0;
    sout.a = 1'b0;
    report_every = 8'd1;
    skip_zero = 1'b0;
    clr_warn = 1'b0;
    test_reset();
    test_single();
    test_decimate();
    test_back_to_back();
    test_off_then_on();
    test_sat_warn();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
